// File: rtl/lcd_cmd_seq_if.sv
// Bus between the LCD init sequencer, its command ROM, the SPI panel pins
// and the top-level controller.
//
// Handshake: start is a single-cycle request. It is taken only while the
// sequencer is idle or done; busy rises on the cycle after the request is
// taken. The request is complete when done rises, and busy falls in that
// same cycle. A start seen while busy is dropped and has no effect.
// The ROM is combinational: rom_data/rom_dc must follow rom_addr within the
// same cycle.
interface lcd_cmd_seq_if;
  logic        start;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_dc;
  logic        lcd_sclk;
  logic        lcd_mosi;
  logic        lcd_cs_n;
  logic        lcd_dc;
  logic        busy;
  logic        done;

  modport master (
    input  start, rom_data, rom_dc,
    output rom_addr, lcd_sclk, lcd_mosi, lcd_cs_n, lcd_dc, busy, done
  );

  modport slave (
    output start, rom_data, rom_dc,
    input  rom_addr, lcd_sclk, lcd_mosi, lcd_cs_n, lcd_dc, busy, done
  );
endinterface

// File: rtl/lcd_cmd_seq.sv
// LCD initialisation sequencer: walks the command ROM and sends each byte
// over 4-wire SPI (mode 0, MSB first) with its DC flag, holding an extra
// delay after sleep-out (0x11 as a command). Every output is registered.
module lcd_cmd_seq #(
  parameter int CMD_COUNT  = 85,
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 2,
  parameter int SLEEP_WAIT = 6000000
) (
  input  logic              clk,
  input  logic              rst,
  lcd_cmd_seq_if.master     bus,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_GAP   = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // One shared counter serves the SCLK divider, the inter-byte gap and the
  // sleep-out wait, so it is sized for the largest of the three.
  localparam int MAX_AB  = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CNT_MAX = (MAX_AB > SLEEP_WAIT) ? MAX_AB : SLEEP_WAIT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'((SLEEP_WAIT > 0) ? SLEEP_WAIT - 1 : 0);
  localparam logic [15:0]   ADDR_END  = 16'(CMD_COUNT);

  state_t      state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]  tog, tog_n;
  logic [7:0]  sh, sh_n;
  logic        sleep_flag, sleep_flag_n;
  logic [15:0] rom_addr, rom_addr_n;
  logic        sclk, sclk_n;
  logic        mosi, mosi_n;
  logic        cs_n, cs_n_n;
  logic        dc, dc_n;
  logic        busy, busy_n;
  logic        done, done_n;
  logic        leave;

  // Register every piece of state; reset forces all outputs to idle values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      tog        <= '0;
      sh         <= '0;
      sleep_flag <= 1'b0;
      rom_addr   <= '0;
      sclk       <= 1'b0;
      mosi       <= 1'b0;
      cs_n       <= 1'b1;
      dc         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      tog        <= tog_n;
      sh         <= sh_n;
      sleep_flag <= sleep_flag_n;
      rom_addr   <= rom_addr_n;
      sclk       <= sclk_n;
      mosi       <= mosi_n;
      cs_n       <= cs_n_n;
      dc         <= dc_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

  // Next-state and next-output logic; chip select is dropped on the same
  // edge that enters LOAD so it is already low during the LOAD cycle.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    tog_n        = tog;
    sh_n         = sh;
    sleep_flag_n = sleep_flag;
    rom_addr_n   = rom_addr;
    sclk_n       = sclk;
    mosi_n       = mosi;
    cs_n_n       = cs_n;
    dc_n         = dc;
    busy_n       = busy;
    done_n       = done;
    leave        = 1'b0;

    case (state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          rom_addr_n = '0;
          busy_n     = 1'b1;
          done_n     = 1'b0;
          cs_n_n     = 1'b0;
          cnt_n      = '0;
          state_n    = S_LOAD;
        end
      end
      S_LOAD: begin
        sh_n         = bus.rom_data;
        dc_n         = bus.rom_dc;
        mosi_n       = bus.rom_data[7];
        sclk_n       = 1'b0;
        cs_n_n       = 1'b0;
        sleep_flag_n = (bus.rom_data == 8'h11) && !bus.rom_dc;
        cnt_n        = '0;
        tog_n        = '0;
        state_n      = S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt == DIV_LAST) begin
          cnt_n  = '0;
          sclk_n = ~sclk;
          tog_n  = tog + 4'd1;
          // Falling edge: present the next bit while SCLK is low.
          if (sclk && (tog != 4'd15)) begin
            sh_n   = {sh[6:0], 1'b0};
            mosi_n = sh[6];
          end
          if (tog == 4'd15) begin
            cs_n_n     = 1'b1;
            rom_addr_n = rom_addr + 16'd1;
            state_n    = S_GAP;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_n = '0;
          if (sleep_flag && (SLEEP_WAIT > 0)) state_n = S_WAIT;
          else                                leave   = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt == WAIT_LAST) begin
          cnt_n = '0;
          leave = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Common exit from GAP/WAIT: finish the sequence or fetch the next byte.
    if (leave) begin
      sleep_flag_n = 1'b0;
      if (rom_addr == ADDR_END) begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = S_DONE;
      end else begin
        cs_n_n  = 1'b0;
        state_n = S_LOAD;
      end
    end
  end

  assign bus.rom_addr = rom_addr;
  assign bus.lcd_sclk = sclk;
  assign bus.lcd_mosi = mosi;
  assign bus.lcd_cs_n = cs_n;
  assign bus.lcd_dc   = dc;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign state_dbg    = state;

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Bench for lcd_cmd_seq: a slow-clock instance running the full 85-entry
// sequence and a fast instance (CLK_DIV=1) sending two bytes, both fed by
// a bench-side command ROM and watched by an SPI byte monitor.
module tb_lcd_cmd_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int vectors     = 0;
  int miscompares = 0;
  int e0          = 0;

  lcd_cmd_seq_if ifa ();
  lcd_cmd_seq_if ifb ();
  logic [2:0] state_a, state_b;

  // ---------------- command ROM model ({dc, data}) ----------------
  function automatic logic [8:0] rom_entry(input logic [15:0] a);
    logic [15:0] t;
    if (a == 16'd0) return {1'b0, 8'h11};
    if (a == 16'd1) return {1'b0, 8'hB1};
    t = a * 16'd7 + 16'd3;
    return {((a % 16'd3) != 16'd0), t[7:0]};
  endfunction

  logic [8:0] ent_a, ent_b;
  assign ent_a        = rom_entry(ifa.rom_addr);
  assign ent_b        = rom_entry(ifb.rom_addr);
  assign ifa.rom_data = ent_a[7:0];
  assign ifa.rom_dc   = ent_a[8];
  assign ifb.rom_data = ent_b[7:0];
  assign ifb.rom_dc   = ent_b[8];

  lcd_cmd_seq #(.CMD_COUNT(85), .CLK_DIV(2), .GAP_CYCLES(2), .SLEEP_WAIT(10)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (ifa),
    .state_dbg (state_a)
  );

  lcd_cmd_seq #(.CMD_COUNT(2), .CLK_DIV(1), .GAP_CYCLES(2), .SLEEP_WAIT(1)) u_fast (
    .clk       (clk),
    .rst       (rst),
    .bus       (ifb),
    .state_dbg (state_b)
  );

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];
  logic [8:0] exp_fast_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_all(input int id, input int count);
    for (int i = 0; i < count; i++) begin
      if (id == 0) exp_q.push_back(rom_entry(16'(i)));
      else         exp_fast_q.push_back(rom_entry(16'(i)));
    end
  endtask

  // ---------------- SPI monitor ----------------
  logic       p_sclk [2];
  logic       p_mosi [2];
  logic       p_dc   [2];
  logic [7:0] mon_sr [2];
  int         mon_bits  [2] = '{0, 0};
  int         mon_bytes [2] = '{0, 0};
  int         unstable  [2] = '{0, 0};

  task automatic mon_step(input int id, input logic sclk, input logic mosi,
                          input logic dc, input logic cs_n);
    logic [8:0] e;
    logic       have;
    if (rst) begin
      mon_bits[id] = 0;
    end else begin
      if (p_sclk[id] === 1'b1 && sclk === 1'b1 &&
          (mosi !== p_mosi[id] || dc !== p_dc[id]))
        unstable[id]++;
      if (p_sclk[id] === 1'b0 && sclk === 1'b1 && cs_n === 1'b0) begin
        mon_sr[id] = {mon_sr[id][6:0], mosi};
        mon_bits[id]++;
        if (mon_bits[id] == 8) begin
          mon_bits[id] = 0;
          mon_bytes[id]++;
          have = 1'b0;
          e    = '0;
          if (id == 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front(); have = 1'b1;
          end else if (id == 1 && exp_fast_q.size() > 0) begin
            e = exp_fast_q.pop_front(); have = 1'b1;
          end
          if (have) begin
            check(id == 0 ? "spi_byte_a" : "spi_byte_b", {23'd0, dc, mon_sr[id]}, {23'd0, e});
          end else begin
            vectors++;
            miscompares++;
            $error("FAIL spi_extra_byte[%0d]: observed %0h expected no byte", id, {dc, mon_sr[id]});
          end
        end
      end
    end
    p_sclk[id] = sclk;
    p_mosi[id] = mosi;
    p_dc[id]   = dc;
  endtask

  // Sample both SPI ports on the falling clock edge, away from updates.
  always @(negedge clk) begin
    mon_step(0, ifa.lcd_sclk, ifa.lcd_mosi, ifa.lcd_dc, ifa.lcd_cs_n);
    mon_step(1, ifb.lcd_sclk, ifb.lcd_mosi, ifb.lcd_dc, ifb.lcd_cs_n);
  end

  // ---------------- driver tasks ----------------
  function automatic logic cs_of(input int id);
    return (id == 0) ? ifa.lcd_cs_n : ifb.lcd_cs_n;
  endfunction
  function automatic logic sclk_of(input int id);
    return (id == 0) ? ifa.lcd_sclk : ifb.lcd_sclk;
  endfunction
  function automatic logic done_of(input int id);
    return (id == 0) ? ifa.done : ifb.done;
  endfunction
  function automatic logic busy_of(input int id);
    return (id == 0) ? ifa.busy : ifb.busy;
  endfunction

  // Returns at the negedge of cycle 1 (the LOAD cycle).
  task automatic pulse_start(input int id);
    @(negedge clk);
    if (id == 0) ifa.start = 1'b1; else ifb.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    e0 = cyc;
  endtask

  task automatic run_len(input int id, input logic level, output int n, output int hi);
    n  = 0;
    hi = 0;
    while (cs_of(id) === level && n < 5000) begin
      n++;
      if (sclk_of(id) === 1'b1) hi++;
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input int id, output int rel, output int idle_gaps);
    int k;
    k         = 0;
    rel       = -1;
    idle_gaps = 0;
    while (k < 5000) begin
      if (done_of(id) === 1'b1) begin
        rel = cyc - e0 + 1;
        break;
      end
      if (busy_of(id) !== 1'b1) idle_gaps++;
      k++;
      @(negedge clk);
    end
  endtask

  task automatic wait_rel(input int target);
    while (cyc - e0 + 1 < target) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n, hi, rel, gaps, k;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // reset values
    check("rst_state",    state_a, 0);
    check("rst_rom_addr", ifa.rom_addr, 0);
    check("rst_sclk",     ifa.lcd_sclk, 0);
    check("rst_mosi",     ifa.lcd_mosi, 0);
    check("rst_cs_n",     ifa.lcd_cs_n, 1);
    check("rst_dc",       ifa.lcd_dc, 0);
    check("rst_busy",     ifa.busy, 0);
    check("rst_done",     ifa.done, 0);
    rst = 1'b0;

    // fast instance: SCLK toggles every cycle, 17+2 cycles per byte
    push_all(1, 2);
    pulse_start(1);
    check("fast_cs_low_c1", ifb.lcd_cs_n, 0);
    run_len(1, 1'b0, n, hi);
    check("fast_byte0_cs_low", n, 17);
    check("fast_byte0_sclk_hi", hi, 8);
    run_len(1, 1'b1, n, hi);
    check("fast_gap_wait", n, 3);
    run_len(1, 1'b0, n, hi);
    check("fast_byte1_cs_low", n, 17);
    wait_done(1, rel, gaps);
    check("fast_done_cycle", rel, 40);
    check("fast_bytes", mon_bytes[1], 2);
    check("fast_q_empty", exp_fast_q.size(), 0);

    // first byte framing and full sequence
    mon_bytes[0] = 0;
    push_all(0, 85);
    pulse_start(0);
    check("c1_cs_n", ifa.lcd_cs_n, 0);
    check("c1_busy", ifa.busy, 1);
    check("c1_state_load", state_a, 1);
    run_len(0, 1'b0, n, hi);
    check("byte0_cs_low", n, 33);
    check("byte0_sclk_hi", hi, 16);
    run_len(0, 1'b1, n, hi);
    check("sleep_gap_wait", n, 12);
    check("byte1_addr", ifa.rom_addr, 1);
    check("byte1_state_load", state_a, 1);
    wait_done(0, rel, gaps);
    check("full_done_cycle", rel, 2986);
    check("full_busy_gaps", gaps, 0);
    check("full_busy_low_at_done", ifa.busy, 0);
    check("full_bytes", mon_bytes[0], 85);
    check("full_q_empty", exp_q.size(), 0);
    check("done_rom_addr", ifa.rom_addr, 85);
    check("done_cs_n", ifa.lcd_cs_n, 1);
    check("done_sclk", ifa.lcd_sclk, 0);

    // restart from DONE, with ignored start pulses mid-sequence
    mon_bytes[0] = 0;
    push_all(0, 85);
    pulse_start(0);
    check("restart_done_clear", ifa.done, 0);
    check("restart_rom_addr", ifa.rom_addr, 0);
    check("restart_busy", ifa.busy, 1);
    wait_rel(500);
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    wait_rel(1200);
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    wait_done(0, rel, gaps);
    check("ignored_start_done_cycle", rel, 2986);
    check("ignored_start_busy_gaps", gaps, 0);
    check("ignored_start_bytes", mon_bytes[0], 85);
    check("ignored_start_q_empty", exp_q.size(), 0);

    // reset during SHIFT of byte 40, then resend from the top
    mon_bytes[0] = 0;
    push_all(0, 85);
    pulse_start(0);
    k = 0;
    while (!(ifa.rom_addr == 16'd40 && state_a == 3'd2 && ifa.lcd_sclk === 1'b1) && k < 5000) begin
      k++;
      @(negedge clk);
    end
    check("reach_byte40_shift", (k < 5000), 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_cs_n", ifa.lcd_cs_n, 1);
    check("midrst_sclk", ifa.lcd_sclk, 0);
    check("midrst_rom_addr", ifa.rom_addr, 0);
    check("midrst_busy", ifa.busy, 0);
    check("midrst_done", ifa.done, 0);
    check("midrst_state", state_a, 0);
    check("midrst_bytes_before", mon_bytes[0], 40);
    exp_q.delete();
    rst = 1'b0;
    mon_bytes[0] = 0;
    push_all(0, 85);
    pulse_start(0);
    wait_done(0, rel, gaps);
    check("after_rst_done_cycle", rel, 2986);
    check("after_rst_bytes", mon_bytes[0], 85);
    check("after_rst_q_empty", exp_q.size(), 0);

    // MOSI/DC never moved while SCLK was high on either instance
    check("stable_a", unstable[0], 0);
    check("stable_b", unstable[1], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lcd_cmd_seq.md
# lcd_cmd_seq

Sequencer and SPI transmitter that walks the LCD initialisation command ROM, one entry per byte, and serialises each byte to the panel with its data/command flag. It drives the ROM address, takes the combinational byte and DC bit back in the same cycle, and produces the 4-wire SPI signals `lcd_sclk`, `lcd_mosi`, `lcd_cs_n` and `lcd_dc`. It holds a post-sleep-out delay and reports completion to the top-level controller, which then starts pixel traffic.

## Interface

Parameters:
- `CMD_COUNT`, 85: number of ROM entries sent, at addresses 0..CMD_COUNT-1.
- `CLK_DIV`, 4: `clk` cycles per SCLK half-period; must be ≥1.
- `GAP_CYCLES`, 2: `clk` cycles with `lcd_cs_n` high between bytes; must be ≥1.
- `SLEEP_WAIT`, 6000000: extra `clk` cycles held after the sleep-out command (0x11 with DC=0).

Ports (clock and reset first):
- `clk` in 1: system clock. One clock domain; every output is registered.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request to send the sequence. Sampled only in IDLE or DONE.
- `rom_addr` out 16: ROM address.
- `rom_data` in 8: ROM byte, combinational from `rom_addr`.
- `rom_dc` in 1: ROM DC bit, combinational from `rom_addr`; 1 = data, 0 = command.
- `lcd_sclk` out 1: SPI clock, mode 0, idles low.
- `lcd_mosi` out 1: SPI data, MSB first.
- `lcd_cs_n` out 1: chip select, active low.
- `lcd_dc` out 1: DC line to the panel.
- `busy` out 1: high from start acceptance until entry to DONE.
- `done` out 1: high in DONE; cleared by `start` or `rst`.

## Operation

Reset values: `rom_addr`=0, `lcd_sclk`=0, `lcd_mosi`=0, `lcd_cs_n`=1, `lcd_dc`=0, `busy`=0, `done`=0, state IDLE.

States:
- IDLE: wait for `start`. When `start` is sampled, set `rom_addr`=0, `busy`=1, `done`=0, and go to LOAD.
- LOAD (1 cycle):
  - Capture `rom_data` into the shift register and `rom_dc` into `lcd_dc`.
  - Drive `lcd_cs_n`=0, `lcd_mosi`=bit 7, `lcd_sclk`=0.
  - Latch a `sleep_flag` when `rom_data`=0x11 and `rom_dc`=0.
  - Go to SHIFT.
- SHIFT: a divider counts 0..CLK_DIV-1 and toggles `lcd_sclk` at terminal count, 16 toggles in total.
  - On each falling toggle except the last, shift the register and drive the next bit on `lcd_mosi`.
  - After the 16th toggle (SCLK back low), increment `rom_addr` and go to GAP.
- GAP: `lcd_cs_n`=1 for GAP_CYCLES cycles. Then:
  - if `sleep_flag` is set, go to WAIT;
  - else if `rom_addr`==CMD_COUNT, go to DONE;
  - else go to LOAD.
- WAIT: `lcd_cs_n`=1 for SLEEP_WAIT cycles. Clear `sleep_flag`, then take the same exit as GAP (DONE or LOAD).
- DONE: `done`=1, `busy`=0, `lcd_cs_n`=1, `lcd_sclk`=0. `rom_addr` stays at CMD_COUNT. `start` restarts exactly as from IDLE.

Rules:
- `lcd_dc` and `lcd_mosi` are stable while `lcd_sclk` is high. `lcd_dc` changes only in LOAD.
- `start` during LOAD, SHIFT, GAP or WAIT is ignored.
- `rst` in any state returns every output to its reset value on the next edge. No partial byte is completed.
- Counter widths must hold CLK_DIV-1, GAP_CYCLES-1 and SLEEP_WAIT-1 without wrap.

## Timing

- Start latency: `start` sampled at edge 0 puts the block in LOAD in cycle 1, with `lcd_cs_n` low from cycle 1.
- Per byte: 1 + 16·CLK_DIV + GAP_CYCLES cycles, plus SLEEP_WAIT after 0x11/DC=0.
- SCLK period is 2·CLK_DIV cycles. The first rising edge comes CLK_DIV cycles after LOAD ends.
- End of sequence: `done` rises and `busy` falls in the same cycle.

## Test plan

Common settings: CLK_DIV=2, GAP_CYCLES=2, SLEEP_WAIT=10, with the real 85-entry ROM attached.

1. Reset, then a `start` pulse -> first byte on MOSI is 00010001 with DC=0. `lcd_cs_n` is low for 33 cycles, high for 2, then high for 10 more before byte 1 (0xB1, DC=0).
2. Full sequence with a SPI monitor -> 85 bytes captured that match ROM bytes and DC bits in order. `done` is first high 2986 cycles after the start-sampling edge; `busy` is high for cycles 1..2985.
3. `start` pulsed at cycle 500 and again at cycle 1200 -> no restart; the byte stream and the `done` timing are identical to scenario 2.
4. `rst` asserted mid-SHIFT of byte 40 -> on the next cycle `lcd_cs_n`=1, `lcd_sclk`=0, `rom_addr`=0, `busy`=0. A following `start` resends from 0x11.
5. `start` in DONE -> `done` clears next cycle, `rom_addr`=0, and a second full identical stream is sent.
6. CLK_DIV=1, SLEEP_WAIT=1 -> SCLK toggles every cycle, a byte takes 17+2 cycles, and MOSI never changes while SCLK is high.
